tank_fill_controller: RTL and testbench

- Sequences the water tank's inlet valve and supply pump from the three level sensors.
- Pipeline: synchronises and debounces highLevel/mediumLevel/lowLevel, then runs a fill state machine and grants supply requests with dry-run protection.
- Publishes a 2-bit debounced level code for the tank display driver.
- Sits between raw sensor pins and the display/actuator outputs.

---
 rtl/tank_pkg.sv | 29 ++
 rtl/sensor_debounce.sv | 41 ++++
 rtl/tank_fill_controller.sv | 127 ++++++++++++
 tb/tb_tank_fill_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types, level codes and sensor-combination helpers for the tank fill controller.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    FAULT   = 2'd2
  } tankState_t;

  localparam logic [1:0] LEVEL_EMPTY  = 2'd0;
  localparam logic [1:0] LEVEL_LOW    = 2'd1;
  localparam logic [1:0] LEVEL_MEDIUM = 2'd2;
  localparam logic [1:0] LEVEL_HIGH   = 2'd3;

  // Sensors are stacked, so only "filled from the bottom" patterns are physical.
  function automatic logic validCombo(input logic h, input logic m, input logic l);
    return (!h && !m) || (!h && m && l) || (h && m && l);
  endfunction

  function automatic logic [1:0] levelOf(input logic h, input logic m, input logic l);
    logic [1:0] code;
    code = LEVEL_EMPTY;
    if (h)      code = LEVEL_HIGH;
    else if (m) code = LEVEL_MEDIUM;
    else if (l) code = LEVEL_LOW;
    return code;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-disagreement debounce counter for one sensor bit.
module sensor_debounce
  import tank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          syncA;
  logic          syncB;
  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncA    <= 1'b0;
      syncB    <= 1'b0;
      count    <= '0;
      filtered <= 1'b0;
    end else begin
      syncA <= raw;
      syncB <= syncA;
      if (syncB != filtered) begin
        if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
          filtered <= syncB;
          count    <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/tank_fill_controller.sv
// Tank inlet/pump sequencer: debounced level sensors, fill FSM, dry-run lockout.
// Optional fill watchdog enabled by defining TANK_FILL_WATCHDOG_EN.
module tank_fill_controller
  import tank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FILL_TIMEOUT    = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       highLevel,
  input  logic       mediumLevel,
  input  logic       lowLevel,
  input  logic       supplyRequest,
  input  logic       faultClear,
  output logic       valveIn,
  output logic       pumpOn,
  output logic [1:0] levelCode,
  output logic       sensorError,
  output logic       fault
);

  localparam int unsigned SW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          filtH;
  logic          filtM;
  logic          filtL;
  logic          filtLPrev;
  logic          settle;
  logic [SW-1:0] settleCnt;
  logic          dryLock;
  logic          fillTimeout;
  tankState_t    state;
  tankState_t    stateNext;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebH (
    .clock(clock), .reset(reset), .raw(highLevel), .filtered(filtH)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebM (
    .clock(clock), .reset(reset), .raw(mediumLevel), .filtered(filtM)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebL (
    .clock(clock), .reset(reset), .raw(lowLevel), .filtered(filtL)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settleCnt <= '0;
      settle    <= 1'b0;
    end else if (!settle) begin
      if (settleCnt == SW'(DEBOUNCE_CYCLES - 1)) settle <= 1'b1;
      else                                       settleCnt <= settleCnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      levelCode   <= LEVEL_EMPTY;
      sensorError <= 1'b0;
    end else if (validCombo(filtH, filtM, filtL)) begin
      levelCode   <= levelOf(filtH, filtM, filtL);
      sensorError <= 1'b0;
    end else begin
      sensorError <= 1'b1;
    end
  end

`ifdef TANK_FILL_WATCHDOG_EN
  localparam int unsigned TW = $clog2(FILL_TIMEOUT + 1);
  logic [TW-1:0] fillCnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fillCnt <= '0;
    end else if (state != FILLING && stateNext == FILLING) begin
      fillCnt <= '0;
    end else if (state == FILLING && fillCnt != TW'(FILL_TIMEOUT)) begin
      fillCnt <= fillCnt + 1'b1;
    end
  end

  assign fillTimeout = (state == FILLING) && (fillCnt == TW'(FILL_TIMEOUT - 1));
`else
  // Constant zero; the term only keeps the parameter referenced in this build.
  assign fillTimeout = 1'b0 & (FILL_TIMEOUT == 0);
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (sensorError)           stateNext = FAULT;
        else if (settle && !filtM) stateNext = FILLING;
      end
      FILLING: begin
        if (sensorError)      stateNext = FAULT;
        else if (filtH)       stateNext = IDLE;
        else if (fillTimeout) stateNext = FAULT;
      end
      FAULT: begin
        if (faultClear && !sensorError) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valveIn   <= 1'b0;
      fault     <= 1'b0;
      pumpOn    <= 1'b0;
      filtLPrev <= 1'b0;
      dryLock   <= 1'b0;
    end else begin
      state     <= stateNext;
      valveIn   <= (stateNext == FILLING);
      fault     <= (stateNext == FAULT);
      pumpOn    <= supplyRequest && filtL && !dryLock && settle && (stateNext != FAULT);
      filtLPrev <= filtL;
      if (filtM)                             dryLock <= 1'b0;
      else if (pumpOn && filtLPrev && !filtL) dryLock <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tank_fill_controller.sv
// Scoreboard bench for tank_fill_controller: sample-window reference model feeds an expectation queue.
module tb_tank_fill_controller;

  localparam int unsigned DB = 16;
  localparam int unsigned TO = 100;
`ifdef TANK_FILL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int MS_IDLE  = 0;
  localparam int MS_FILL  = 1;
  localparam int MS_FAULT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       highLevel = 1'b0, mediumLevel = 1'b0, lowLevel = 1'b0;
  logic       supplyRequest = 1'b0, faultClear = 1'b0;
  logic       valveIn, pumpOn, sensorError, fault;
  logic [1:0] levelCode;

  tank_fill_controller #(.DEBOUNCE_CYCLES(DB), .FILL_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .highLevel(highLevel), .mediumLevel(mediumLevel), .lowLevel(lowLevel),
    .supplyRequest(supplyRequest), .faultClear(faultClear),
    .valveIn(valveIn), .pumpOn(pumpOn), .levelCode(levelCode),
    .sensorError(sensorError), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       valve;
    logic       pump;
    logic [1:0] lvl;
    logic       err;
    logic       flt;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic done = 1'b0;
  logic rstSampled = 1'b0;
  logic rstValve = 1'b1;

  // Reference model: raw-sample history windows, edge counting since reset.
  logic [DB+1:0] hH, hM, hL;
  logic          fH, fM, fL, fLp, mSettle, mErr, mPump, mDry;
  logic [1:0]    mLvl;
  int            mState;
  int unsigned   edges, entryEdge;

  function automatic logic windowFilter(input logic [DB+1:0] h, input logic f);
    logic [DB-1:0] w;
    w = h[DB+1:2];
    if (w == '1) return 1'b1;
    if (w == '0) return 1'b0;
    return f;
  endfunction

  function automatic logic physical(input logic [2:0] hml);
    return hml inside {3'b000, 3'b001, 3'b011, 3'b111};
  endfunction

  task automatic modelReset();
    hH = '0; hM = '0; hL = '0;
    fH = 0; fM = 0; fL = 0; fLp = 0;
    mSettle = 0; mErr = 0; mPump = 0; mDry = 0; mLvl = 2'd0;
    mState = MS_IDLE; edges = 0; entryEdge = 0;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        modelReset();
        expQ.delete();
      end else begin
        logic       nErr, nPump, nDry;
        logic [1:0] nLvl;
        int         nS;
        edges++;
        nErr = !physical({fH, fM, fL});
        nLvl = nErr ? mLvl : ({1'b0, fH} + {1'b0, fM} + {1'b0, fL});
        nS = mState;
        case (mState)
          MS_IDLE:
            if (mErr) nS = MS_FAULT;
            else if (mSettle && !fM) begin nS = MS_FILL; entryEdge = edges; end
          MS_FILL:
            if (mErr) nS = MS_FAULT;
            else if (fH) nS = MS_IDLE;
            else if (WD && (edges - entryEdge == TO)) nS = MS_FAULT;
          default:
            if (faultClear && !mErr) nS = MS_IDLE;
        endcase
        nPump = supplyRequest && fL && !mDry && mSettle && (nS != MS_FAULT);
        nDry  = fM ? 1'b0 : ((mPump && fLp && !fL) ? 1'b1 : mDry);
        hH = {hH[DB:0], highLevel};
        hM = {hM[DB:0], mediumLevel};
        hL = {hL[DB:0], lowLevel};
        fLp = fL;
        fH = windowFilter(hH, fH);
        fM = windowFilter(hM, fM);
        fL = windowFilter(hL, fL);
        mSettle = (edges >= DB);
        mState = nS; mErr = nErr; mLvl = nLvl; mPump = nPump; mDry = nDry;
        expQ.push_back('{valve: (nS == MS_FILL), pump: nPump, lvl: nLvl,
                         err: nErr, flt: (nS == MS_FAULT)});
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one popped expectation per clock, compared on the falling edge.
  initial begin
    logic rstChecked;
    exp_t e;
    rstChecked = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (reset) begin
        check("reset outputs", {2'b0, valveIn, pumpOn, levelCode, sensorError, fault}, 8'h00);
        if (rstSampled && !rstChecked) begin
          check("async valve close", {7'b0, rstValve}, 8'h00);
          rstChecked = 1'b1;
        end
      end else if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("valveIn",     {7'b0, valveIn},     {7'b0, e.valve});
        check("pumpOn",      {7'b0, pumpOn},      {7'b0, e.pump});
        check("levelCode",   {6'b0, levelCode},   {6'b0, e.lvl});
        check("sensorError", {7'b0, sensorError}, {7'b0, e.err});
        check("fault",       {7'b0, fault},       {7'b0, e.flt});
      end
    end
    if (!rstChecked) check("async reset exercised", 8'h00, 8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic sensors(input logic h, input logic m, input logic l);
    highLevel = h; mediumLevel = m; lowLevel = l;
  endtask

  task automatic pulseClear();
    faultClear = 1'b1;
    step(1);
    faultClear = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    supplyRequest = 1'b1;
    sensors(0, 0, 0); step(30);      // fill starts once settled
    sensors(0, 0, 1); step(50);
    sensors(0, 1, 1); step(50);
    sensors(1, 1, 1); step(50);      // valve closes when H is filtered
    sensors(1, 0, 1); step(40);      // invalid -> fault
    pulseClear();     step(10);      // ignored while invalid
    sensors(1, 1, 1); step(30);
    pulseClear();     step(10);
    sensors(0, 1, 1); step(40);      // pump on
    sensors(0, 0, 0); step(40);      // dry lock
    sensors(0, 0, 1); step(40);      // still locked
    sensors(0, 1, 1); step(40);      // released by medium
    lowLevel = 1'b0;  step(5);       // short glitch
    lowLevel = 1'b1;  step(30);
    sensors(0, 0, 0); step(40);      // filling
    reset = 1'b1;
    #1;
    rstValve = valveIn;
    rstSampled = 1'b1;
    step(3);
    reset = 1'b0;
    sensors(0, 0, 1); step(150);     // long fill: watchdog timeout when enabled
    pulseClear();     step(10);

    for (int unsigned seg = 0; seg < 120; seg++) begin
      int unsigned pick, len;
      logic [2:0]  code;
      pick = $urandom_range(0, 11);
      case (pick)
        0, 1, 2:  code = 3'b000;
        3, 4, 5:  code = 3'b001;
        6, 7:     code = 3'b011;
        8, 9:     code = 3'b111;
        default:  code = 3'($urandom_range(0, 7));
      endcase
      len = $urandom_range(2, 45);
      for (int unsigned c = 0; c < len; c++) begin
        logic [2:0] g;
        g = code;
        if ($urandom_range(0, 14) == 0) g[$urandom_range(0, 2)] = ~g[$urandom_range(0, 2)];
        sensors(g[2], g[1], g[0]);
        if ($urandom_range(0, 9) == 0) supplyRequest = ~supplyRequest;
        faultClear = ($urandom_range(0, 19) == 0);
        step(1);
      end
    end
    faultClear = 1'b0;
    step(2);
    done = 1'b1;
  end

endmodule
